// File: rtl/synchronous_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// synchronous_fifo_stream_reader
//
// Purpose:
//   Drains the egress side of a synchronous FIFO (empty flag, read strobe,
//   read data one cycle after the strobe) and presents the words as a
//   valid/ready stream. egr_tlast is raised on every BURST_LENGTH_P-th beat.
//   A 2-entry skid buffer absorbs the word already in flight when the
//   consumer stalls, so the stream sustains one beat per cycle.
//
// Ports:
//   clk             clock, all state on posedge
//   rst             asynchronous, active-high reset
//   cr_enable       1: issue FIFO reads; 0: stop issuing (buffered/in-flight drain)
//   fifo_empty      FIFO egress empty flag
//   fifo_read_en    FIFO read strobe (combinational, depends on egr_tready)
//   fifo_data       FIFO read data, valid the cycle after fifo_read_en
//   egr_tvalid      stream valid
//   egr_tready      stream ready
//   egr_tdata       stream data (head of the skid buffer)
//   egr_tlast       last beat of a burst
//   sr_burst_count  completed bursts, wraps
// -----------------------------------------------------------------------------
module synchronous_fifo_stream_reader #(
   parameter int DATA_WIDTH_P   = 32,
   parameter int BURST_LENGTH_P = 16,
   parameter int COUNT_WIDTH_P  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cr_enable,
   input  logic                     fifo_empty,
   output logic                     fifo_read_en,
   input  logic [DATA_WIDTH_P-1:0]  fifo_data,
   output logic                     egr_tvalid,
   input  logic                     egr_tready,
   output logic [DATA_WIDTH_P-1:0]  egr_tdata,
   output logic                     egr_tlast,
   output logic [COUNT_WIDTH_P-1:0] sr_burst_count
);

   localparam int BEAT_W = $clog2(BURST_LENGTH_P) + 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LENGTH_P - 1);

   logic [1:0]              cnt;    // occupied skid entries, 0..2
   logic                    inf;    // read issued last cycle, data arrives now
   logic [DATA_WIDTH_P-1:0] head;   // oldest entry, drives egr_tdata
   logic [DATA_WIDTH_P-1:0] tail;   // second entry
   logic [BEAT_W-1:0]       beat;
   logic                    pop;
   logic [2:0]              occ;    // occupancy after this edge, counting the in-flight word

   assign egr_tvalid = (cnt != 2'd0);
   assign egr_tdata  = head;
   assign egr_tlast  = egr_tvalid && (beat == LAST_BEAT);
   assign pop        = egr_tvalid && egr_tready;

   // pop implies cnt>=1, so this never underflows.
   assign occ = {1'b0, cnt} + {2'b00, inf} - {2'b00, pop};

   // A new read lands one edge later; allowing it only when occ<=1 guarantees
   // the buffer never needs a third slot even if the consumer stalls.
   assign fifo_read_en = !rst && cr_enable && !fifo_empty && (occ <= 3'd1);

   // Skid buffer: inf means fifo_data is valid now and is written this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= 2'd0;
         inf  <= 1'b0;
         head <= '0;
         tail <= '0;
      end else begin
         inf <= fifo_read_en;
         case ({inf, pop})
            2'b10: begin
               if (cnt == 2'd0) head <= fifo_data;
               else             tail <= fifo_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               head <= tail;
               cnt  <= cnt - 2'd1;
            end
            2'b11: begin
               // Head leaves, new word enters behind whatever remains.
               if (cnt == 2'd1) head <= fifo_data;
               else begin
                  head <= tail;
                  tail <= fifo_data;
               end
            end
            default: ;
         endcase
      end
   end

   // Beat position within the current burst and completed-burst counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat           <= '0;
         sr_burst_count <= '0;
      end else if (pop) begin
         if (egr_tlast) begin
            beat           <= '0;
            sr_burst_count <= sr_burst_count + 1'b1;
         end else begin
            beat <= beat + 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   // A capture into a full buffer without a simultaneous pop would lose a word.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(inf && !pop && (cnt == 2'd2)));
`endif

endmodule
